// File: rtl/inta_if.sv
// Bus bundle between an interrupt requester/CPU side and the INTA sequencer.
interface inta_if;
    logic [7:0] irr;
    logic       inta_n;
    logic       eoi;
    logic [4:0] vector_base;
    logic       int_out;
    logic [7:0] isr;
    logic [7:0] irr_clear;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (
        output irr, inta_n, eoi, vector_base,
        input  int_out, isr, irr_clear, data_out, data_oe
    );

    modport slave (
        input  irr, inta_n, eoi, vector_base,
        output int_out, isr, irr_clear, data_out, data_oe
    );
endinterface

// File: rtl/inta_sequencer.sv
// Fully nested interrupt acknowledge sequencer: two-pulse INTA handshake, ISR tracking, vector drive.
// Define AEOI_EN to clear the in-service bit automatically at the end of the second INTA pulse.
module inta_sequencer (
    input  logic   clk,
    input  logic   rst,
    inta_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PEND, ACK1, ACK2} state_t;

    state_t     state;
    logic       inta_q, inta_fall, inta_rise;
    logic       seen_rise, spur;
    logic [2:0] sel, lvl;
    logic [7:0] isr, isr_low, mask, eligible;
    logic [7:0] isr_set, eoi_clr, aeoi_clr;
    logic       int_out, data_oe;
    logic [7:0] irr_clear, data_out;

    assign inta_fall = inta_q & ~bus.inta_n;
    assign inta_rise = ~inta_q & bus.inta_n;

    // Only levels strictly more urgent than the most urgent in-service level may interrupt.
    always_comb begin
        isr_low  = isr & (~isr + 8'd1);
        mask     = (isr == 8'd0) ? 8'hFF : (isr_low - 8'd1);
        eligible = bus.irr & mask;
        lvl      = 3'd7;
        for (int i = 7; i >= 0; i--)
            if (eligible[i]) lvl = 3'(i);
    end

    always_comb begin
        isr_set  = 8'd0;
        aeoi_clr = 8'd0;
        eoi_clr  = bus.eoi ? isr_low : 8'd0;
        if (state == PEND && inta_fall && eligible != 8'd0)
            isr_set = 8'd1 << lvl;
`ifdef AEOI_EN
        if (state == ACK2 && inta_rise && !spur)
            aeoi_clr = 8'd1 << sel;
`else
        aeoi_clr = 8'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            inta_q    <= 1'b1;
            int_out   <= 1'b0;
            isr       <= 8'd0;
            irr_clear <= 8'd0;
            data_out  <= 8'd0;
            data_oe   <= 1'b0;
            sel       <= 3'd0;
            seen_rise <= 1'b0;
            spur      <= 1'b0;
        end else begin
            inta_q    <= bus.inta_n;
            irr_clear <= 8'd0;
            // EOI clears against the pre-edge ISR; a simultaneous set still lands.
            isr       <= (isr & ~(eoi_clr | aeoi_clr)) | isr_set;
            case (state)
                IDLE: begin
                    if (eligible != 8'd0) begin
                        int_out <= 1'b1;
                        state   <= PEND;
                    end
                end
                PEND: begin
                    if (inta_fall) begin
                        sel       <= lvl;
                        spur      <= (eligible == 8'd0);
                        seen_rise <= 1'b0;
                        if (eligible != 8'd0) irr_clear <= 8'd1 << lvl;
                        int_out   <= 1'b0;
                        state     <= ACK1;
                    end else if (eligible == 8'd0) begin
                        int_out <= 1'b0;
                        state   <= IDLE;
                    end
                end
                ACK1: begin
                    if (!seen_rise) begin
                        if (inta_rise) seen_rise <= 1'b1;
                    end else if (inta_fall) begin
                        data_out <= {bus.vector_base, sel};
                        data_oe  <= 1'b1;
                        state    <= ACK2;
                    end
                end
                ACK2: begin
                    if (inta_rise) begin
                        data_oe <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.int_out   = int_out;
    assign bus.isr       = isr;
    assign bus.irr_clear = irr_clear;
    assign bus.data_out  = data_out;
    assign bus.data_oe   = data_oe;
endmodule
